bht_arbiter: RTL
================

# bht_arbiter

Shared-table controller for the 2-bit saturating-counter branch predictor. It owns a table of 2^INDEX_W counters and arbitrates a single table access per cycle between the fetch-side lookup port and the execute-side update port. Resolved-branch updates go into a small FIFO so that lookups normally win. A full queue forces a drain so that updates are never starved.

## Interface
- INDEX_W, default 4: table index width; table holds 2^INDEX_W counters.
- Q_DEPTH, default 4: update queue depth; power of two, at least 2.
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- lookup_valid  input  1  lookup request.
- lookup_index  input  INDEX_W  counter to read.
- lookup_ready  output  1  lookup accepted this cycle when high together with lookup_valid.
- prediction  output  1  taken prediction, the MSB of the counter that was read.
- prediction_valid  output  1  one-cycle pulse qualifying prediction.
- update_valid  input  1  resolved-branch update offered.
- update_index  input  INDEX_W  counter to update.
- update_taken  input  1  branch outcome: 1 = taken.
- update_ready  output  1  queue can accept an update this cycle.
- idle  output  1  update queue empty.

## Operation
- Table: 2^INDEX_W 2-bit registers. Encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Counter update rules:
  - Taken increments the counter and saturates at 11.
  - Not-taken decrements the counter and saturates at 00.
- Update queue:
  - Circular FIFO with entries {index, taken}.
  - Read and write pointers wrap modulo Q_DEPTH.
  - Occupancy count is log2(Q_DEPTH)+1 bits wide.
- Enqueue happens when update_valid && update_ready.
  - update_ready = !full.
  - update_ready is computed from registered occupancy. A dequeue in the same cycle does not open a slot for an enqueue when the queue is full.
- Each cycle exactly one grant is made, in this priority order:
  1. DRAIN: the queue is full. Pop the head and write its updated counter. lookup_ready = 0.
  2. LOOKUP: lookup_valid is high and the queue is not full. Read table[lookup_index]. lookup_ready = 1.
  3. UPDATE: no lookup is pending and the queue is not empty. Pop the head and write its updated counter.
  4. Otherwise no access.
- lookup_ready is low only when the queue is full. It is a combinational function of occupancy and does not depend on lookup_valid.
- No forwarding:
  - A lookup returns the table contents as they stood before the current clock edge.
  - Updates still in the queue are not visible to lookups.
- A simultaneous enqueue and dequeue leaves occupancy unchanged.
- Updates are applied strictly in FIFO order. Repeated updates to the same index accumulate correctly because each dequeue reads the current table value.
- Reset, effective immediately and independent of clk:
  - All counters set to 01.
  - Queue emptied; both pointers set to 0.
  - prediction = 0, prediction_valid = 0.
  - After reset: update_ready = 1, lookup_ready = 1, idle = 1.
- All inputs are ignored while rst is high.
- Reset asserted mid-operation discards all queued updates and any prediction in flight.

## Timing
- Lookup latency is 1 cycle. A lookup accepted at edge N produces prediction and prediction_valid, registered, in the cycle after edge N.
- prediction holds its last value when prediction_valid is low.
- An update enqueued at edge N is written at edge N+1 at the earliest, when the queue was empty and no lookup is pending in cycle N+1.
- Worst case under continuous lookups:
  - The queue fills after Q_DEPTH enqueues.
  - The next cycle is a DRAIN grant, which stalls lookups for 1 cycle.
  - That stall repeats while the producer keeps the queue full.
- A stalled lookup must hold lookup_valid and lookup_index until lookup_ready is high.
- idle reflects registered occupancy and goes high the cycle after the last dequeue.

## Test plan
- Reset, then look up index 3 → prediction = 0 with a prediction_valid pulse 1 cycle later; idle = 1, update_ready = 1.
- Two taken updates to index 5 with no lookups, then look up index 5 → counter 01→10→11, prediction = 1; a third taken update leaves it at 11.
- Four not-taken updates to index 2 → counter saturates at 00. A following taken update and lookup → counter 01, prediction = 0.
- Lookup every cycle while pushing 5 updates back-to-back with Q_DEPTH = 4:
  - update_ready drops after 4 enqueues.
  - The next cycle is a DRAIN with lookup_ready = 0.
  - The held lookup is accepted the following cycle.
  - The 5th update is accepted once a slot is free, and no update is lost.
- Enqueue a taken update to index 7 and look up index 7 in the next cycle while lookups continue → prediction = 0 (stale, no forwarding). After lookups stop and idle = 1, a lookup returns 1.
- Assert rst asynchronously mid-cycle with 3 queued updates and a prediction pending:
  - Outputs go to reset values immediately and idle = 1.
  - Lookups afterwards return 0, showing the queued updates were discarded.

Source files
------------

// File: rtl/bht_arbiter.sv
// Branch history table of 2-bit saturating counters with one access per cycle,
// arbitrated between fetch lookups and a FIFO of resolved-branch updates.
module bht_arbiter #(
    parameter int INDEX_W = 4,
    parameter int Q_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lookup_valid,
    input  logic [INDEX_W-1:0] lookup_index,
    output logic               lookup_ready,
    output logic               prediction,
    output logic               prediction_valid,
    input  logic               update_valid,
    input  logic [INDEX_W-1:0] update_index,
    input  logic               update_taken,
    output logic               update_ready,
    output logic               idle
);
    localparam int PTR_W   = $clog2(Q_DEPTH);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam logic [PTR_W:0]   FULL_COUNT = Q_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE    = 1;
    localparam logic [PTR_W-1:0] PTR_ONE    = 1;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_DRAIN,
        GRANT_LOOKUP,
        GRANT_UPDATE
    } grant_t;

    logic [1:0]         table_q [ENTRIES];
    logic [INDEX_W-1:0] q_index [Q_DEPTH];
    logic               q_taken [Q_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;

    grant_t             grant;
    logic               full;
    logic               empty;
    logic               enq;
    logic               deq;
    logic [INDEX_W-1:0] head_index;
    logic               head_taken;
    logic [1:0]         head_cnt;
    logic [1:0]         head_next;

    assign full         = (count == FULL_COUNT);
    assign empty        = (count == '0);
    assign lookup_ready = !full;
    assign update_ready = !full;
    assign idle         = empty;
    assign enq          = update_valid && !full;

    // A full queue takes the table ahead of lookups so updates cannot starve.
    always_comb begin
        grant = GRANT_NONE;
        if (full)
            grant = GRANT_DRAIN;
        else if (lookup_valid)
            grant = GRANT_LOOKUP;
        else if (!empty)
            grant = GRANT_UPDATE;
    end

    assign deq        = (grant == GRANT_DRAIN) || (grant == GRANT_UPDATE);
    assign head_index = q_index[rd_ptr];
    assign head_taken = q_taken[rd_ptr];
    assign head_cnt   = table_q[head_index];

    always_comb begin
        head_next = head_cnt;
        if (head_taken) begin
            if (head_cnt != 2'b11)
                head_next = head_cnt + 2'b01;
        end else if (head_cnt != 2'b00) begin
            head_next = head_cnt - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                table_q[i] <= 2'b01;
        end else if (deq) begin
            table_q[head_index] <= head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_index[wr_ptr] <= update_index;
            q_taken[wr_ptr] <= update_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (deq)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Lookups never coincide with a table write, so the read is the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prediction       <= 1'b0;
            prediction_valid <= 1'b0;
        end else begin
            prediction_valid <= (grant == GRANT_LOOKUP);
            if (grant == GRANT_LOOKUP)
                prediction <= table_q[lookup_index][1];
        end
    end
endmodule
